// File: rtl/mem_bus_responder.sv
// Behavioural memory on the multiplexed address/data bus: latches an address on ALE,
// then serves one read (after READ_LAT cycles) or one write per transaction.
module mem_bus_responder #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 1
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              nME,
  input  logic              ALE,
  input  logic              nOE,
  input  logic              nWE,
  input  logic [DATA_W-1:0] BusIn,
  output logic [DATA_W-1:0] BusOut,
  output logic              BusOe,
  output logic              Ready,
  output logic              Err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_W:0] DEPTH_EXT = (DATA_W+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, ADDR, RWAIT, RDRIVE, WDONE, ERR} state_t;

  state_t            state;
  logic [DATA_W-1:0] addr;
  logic [2:0]        count;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic [AW-1:0]     index;
  logic [DATA_W-1:0] read_word;
  logic              both_low;
  logic              mem_we;

  // The low address bits only index the array once the full address is known in range.
  assign in_range  = {1'b0, addr} < DEPTH_EXT;
  assign index     = addr[AW-1:0];
  assign read_word = in_range ? mem[index] : '0;
  assign both_low  = !nOE && !nWE;
  assign mem_we    = (state == ADDR) && !nME && !ALE && nOE && !nWE && in_range;

  // The array is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge Clock) begin
    if (mem_we) mem[index] <= BusIn;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state  <= IDLE;
      addr   <= '0;
      count  <= '0;
      BusOut <= '0;
      BusOe  <= 1'b0;
      Ready  <= 1'b0;
      Err    <= 1'b0;
    end else begin
      BusOe  <= 1'b0;
      Ready  <= 1'b0;
      BusOut <= '0;
      if (nME) begin
        state <= IDLE;
      end else if (ALE) begin
        state <= ADDR;
        addr  <= BusIn;
        Err   <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (both_low) begin
              state <= ERR;
              Err   <= 1'b1;
            end else if (!nOE) begin
              if (!in_range) Err <= 1'b1;
              if (READ_LAT <= 1) begin
                state  <= RDRIVE;
                BusOe  <= 1'b1;
                Ready  <= 1'b1;
                BusOut <= read_word;
              end else begin
                state <= RWAIT;
                count <= 3'(READ_LAT - 1);
              end
            end else if (!nWE) begin
              if (!in_range) Err <= 1'b1;
              state <= WDONE;
              Ready <= 1'b1;
            end
          end
          RWAIT: begin
            if (both_low) begin
              state <= ERR;
              Err   <= 1'b1;
            end else if (count == 3'd1) begin
              state  <= RDRIVE;
              BusOe  <= 1'b1;
              Ready  <= 1'b1;
              BusOut <= read_word;
            end else begin
              count <= count - 3'd1;
            end
          end
          RDRIVE: begin
            // Held nOE re-reads the same word every cycle; no auto-increment.
            if (both_low) begin
              state <= ERR;
              Err   <= 1'b1;
            end else if (nOE) begin
              state <= ADDR;
            end else begin
              BusOe  <= 1'b1;
              Ready  <= 1'b1;
              BusOut <= read_word;
            end
          end
          WDONE: begin
            if (nWE) state <= ADDR;
          end
          ERR: begin
            state <= ERR;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Drives two responders (READ_LAT 1 and 3) with the same bus traffic and checks both
// against a transaction-level model every cycle, plus directed literal checks.
module tb_mem_bus_responder;

  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  logic        clock   = 1'b0;
  logic        n_reset = 1'b0;
  logic        n_me    = 1'b1;
  logic        ale     = 1'b0;
  logic        n_oe    = 1'b1;
  logic        n_we    = 1'b1;
  logic [15:0] bus_in  = 16'h0000;

  logic [15:0] bus_out [2];
  logic        bus_oe  [2];
  logic        ready   [2];
  logic        err     [2];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  mem_bus_responder #(.DATA_W(16), .DEPTH(1024), .READ_LAT(1)) dut_lat1 (
    .Clock(clock), .nReset(n_reset), .nME(n_me), .ALE(ale), .nOE(n_oe), .nWE(n_we),
    .BusIn(bus_in), .BusOut(bus_out[0]), .BusOe(bus_oe[0]), .Ready(ready[0]), .Err(err[0])
  );

  mem_bus_responder #(.DATA_W(16), .DEPTH(1024), .READ_LAT(3)) dut_lat3 (
    .Clock(clock), .nReset(n_reset), .nME(n_me), .ALE(ale), .nOE(n_oe), .nWE(n_we),
    .BusIn(bus_in), .BusOut(bus_out[1]), .BusOe(bus_oe[1]), .Ready(ready[1]), .Err(err[1])
  );

  // Model: per instance, whether a transaction is open, how many edges a read has aged,
  // whether a write is being held, and whether a protocol error has locked it.
  logic        m_open  [2];
  logic [15:0] m_addr  [2];
  logic        m_err   [2];
  logic        m_prot  [2];
  logic        m_wheld [2];
  int          m_age   [2];
  logic        m_oe    [2];
  logic        m_ready [2];
  logic [15:0] m_out   [2];
  logic        m_out_ok[2];
  logic [15:0] m_mem   [2][1024];
  bit          m_known [2][1024];

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      m_open[k] = 1'b0; m_addr[k] = 16'h0000; m_err[k] = 1'b0; m_prot[k] = 1'b0;
      m_wheld[k] = 1'b0; m_age[k] = -1; m_oe[k] = 1'b0; m_ready[k] = 1'b0;
      m_out[k] = 16'h0000; m_out_ok[k] = 1'b0;
    end
  endtask

  task automatic modelStep(input int k);
    int         lat;
    logic       inr;
    logic [9:0] idx;
    lat = (k == 0) ? 1 : 3;
    m_oe[k] = 1'b0; m_ready[k] = 1'b0; m_out_ok[k] = 1'b0;
    if (n_me) begin
      m_open[k] = 1'b0; m_age[k] = -1; m_wheld[k] = 1'b0; m_prot[k] = 1'b0;
      return;
    end
    if (ale) begin
      m_open[k] = 1'b1; m_addr[k] = bus_in; m_err[k] = 1'b0;
      m_age[k] = -1; m_wheld[k] = 1'b0; m_prot[k] = 1'b0;
      return;
    end
    if (!m_open[k] || m_prot[k]) return;
    if (m_wheld[k]) begin
      if (n_we) m_wheld[k] = 1'b0;
      return;
    end
    inr = m_addr[k] < 16'd1024;
    idx = m_addr[k][9:0];
    if (m_age[k] >= 0) begin
      if (!n_oe && !n_we) begin
        m_prot[k] = 1'b1; m_err[k] = 1'b1; m_age[k] = -1;
        return;
      end
      if (m_age[k] >= lat - 1 && n_oe) begin
        m_age[k] = -1;
        return;
      end
      m_age[k]++;
    end else if (!n_oe && !n_we) begin
      m_prot[k] = 1'b1; m_err[k] = 1'b1;
      return;
    end else if (!n_oe) begin
      m_age[k] = 0;
      if (!inr) m_err[k] = 1'b1;
    end else if (!n_we) begin
      if (inr) begin
        m_mem[k][idx] = bus_in;
        m_known[k][idx] = 1'b1;
      end else begin
        m_err[k] = 1'b1;
      end
      m_wheld[k] = 1'b1; m_ready[k] = 1'b1;
      return;
    end else begin
      return;
    end
    if (m_age[k] >= lat - 1) begin
      m_oe[k] = 1'b1; m_ready[k] = 1'b1;
      m_out[k]    = inr ? m_mem[k][idx] : 16'h0000;
      m_out_ok[k] = !inr || m_known[k][idx];
    end
  endtask

  always @(posedge clock or negedge n_reset) begin
    if (!n_reset) modelReset();
    else begin
      modelStep(0);
      modelStep(1);
    end
  end

  always @(negedge clock) begin
    if (n_reset) begin
      for (int k = 0; k < 2; k++) begin
        checkOutput($sformatf("lat%0d BusOe", k * 2 + 1), 16'(bus_oe[k]), 16'(m_oe[k]));
        checkOutput($sformatf("lat%0d Ready", k * 2 + 1), 16'(ready[k]), 16'(m_ready[k]));
        checkOutput($sformatf("lat%0d Err", k * 2 + 1), 16'(err[k]), 16'(m_err[k]));
        if (m_oe[k] && m_out_ok[k])
          checkOutput($sformatf("lat%0d BusOut", k * 2 + 1), bus_out[k], m_out[k]);
      end
    end
  end

  // Inputs change 2 time units after the edge and are sampled by the next edge.
  task automatic applyStimulus(input logic me, input logic a, input logic oe, input logic we,
                               input logic [15:0] bus);
    n_me = me; ale = a; n_oe = oe; n_we = we; bus_in = bus;
    @(posedge clock);
    #2;
  endtask

  task automatic writeWord(input logic [15:0] a, input logic [15:0] d);
    applyStimulus(L, H, H, H, a);
    applyStimulus(L, L, H, L, d);
    applyStimulus(L, L, H, H, 16'h0000);
  endtask

  task automatic startRead(input logic [15:0] a);
    applyStimulus(L, H, H, H, a);
    applyStimulus(L, L, L, H, 16'h0000);
  endtask

  initial begin
    modelReset();
    #12;
    checkOutput("reset BusOut", bus_out[0], 16'h0000);
    checkOutput("reset BusOe", 16'(bus_oe[0]), 16'h0000);
    checkOutput("reset Ready", 16'(ready[1]), 16'h0000);
    checkOutput("reset Err", 16'(err[1]), 16'h0000);
    @(posedge clock);
    #2;
    n_reset = 1'b1;

    applyStimulus(L, H, H, H, 16'h0010);
    applyStimulus(L, L, H, L, 16'hBEEF);
    checkOutput("write ready pulse", 16'(ready[0]), 16'h0001);
    applyStimulus(L, L, H, H, 16'h0000);
    checkOutput("write ready drops", 16'(ready[0]), 16'h0000);
    startRead(16'h0010);
    checkOutput("lat1 read oe", 16'(bus_oe[0]), 16'h0001);
    checkOutput("lat1 read data", bus_out[0], 16'hBEEF);
    checkOutput("lat1 read err", 16'(err[0]), 16'h0000);
    applyStimulus(L, L, H, H, 16'h0000);
    checkOutput("turnaround oe", 16'(bus_oe[0]), 16'h0000);

    writeWord(16'h0005, 16'h1234);
    startRead(16'h0005);
    checkOutput("lat3 wait1 oe", 16'(bus_oe[1]), 16'h0000);
    applyStimulus(L, L, L, H, 16'h0000);
    checkOutput("lat3 wait2 oe", 16'(bus_oe[1]), 16'h0000);
    applyStimulus(L, L, L, H, 16'h0000);
    checkOutput("lat3 read oe", 16'(bus_oe[1]), 16'h0001);
    checkOutput("lat3 read data", bus_out[1], 16'h1234);
    checkOutput("lat3 read ready", 16'(ready[1]), 16'h0001);
    applyStimulus(L, L, H, H, 16'h0000);

    applyStimulus(L, H, H, H, 16'h0020);
    applyStimulus(L, L, H, L, 16'h1111);
    for (int i = 0; i < 3; i++) applyStimulus(L, L, H, L, 16'h2222);
    checkOutput("held write ready", 16'(ready[0]), 16'h0000);
    applyStimulus(L, L, H, H, 16'h0000);
    startRead(16'h0020);
    checkOutput("held write data", bus_out[0], 16'h1111);
    applyStimulus(L, L, L, H, 16'h0000);
    applyStimulus(L, L, L, H, 16'h0000);
    checkOutput("held write data lat3", bus_out[1], 16'h1111);
    applyStimulus(L, L, H, H, 16'h0000);

    writeWord(16'h0030, 16'hAAAA);
    applyStimulus(L, H, H, H, 16'h0030);
    applyStimulus(L, L, L, L, 16'h5555);
    checkOutput("proto err", 16'(err[0]), 16'h0001);
    checkOutput("proto oe", 16'(bus_oe[0]), 16'h0000);
    applyStimulus(L, L, H, H, 16'h0000);
    checkOutput("proto err sticky", 16'(err[1]), 16'h0001);
    startRead(16'h0030);
    checkOutput("proto err cleared", 16'(err[0]), 16'h0000);
    checkOutput("proto word kept", bus_out[0], 16'hAAAA);
    applyStimulus(L, L, H, H, 16'h0000);

    writeWord(16'h0000, 16'h0F0F);
    applyStimulus(L, H, H, H, 16'h0400);
    applyStimulus(L, L, H, L, 16'h5555);
    checkOutput("range write ready", 16'(ready[0]), 16'h0001);
    checkOutput("range write err", 16'(err[0]), 16'h0001);
    applyStimulus(L, L, H, H, 16'h0000);
    startRead(16'h0400);
    checkOutput("range read data", bus_out[0], 16'h0000);
    checkOutput("range read err", 16'(err[0]), 16'h0001);
    checkOutput("range read ready", 16'(ready[0]), 16'h0001);
    applyStimulus(L, L, H, H, 16'h0000);
    startRead(16'h0000);
    checkOutput("word 0 intact", bus_out[0], 16'h0F0F);
    applyStimulus(L, L, H, H, 16'h0000);

    startRead(16'h0010);
    applyStimulus(L, L, L, H, 16'h0000);
    applyStimulus(H, L, L, H, 16'h0000);
    checkOutput("abort oe", 16'(bus_oe[0]), 16'h0000);
    checkOutput("abort ready", 16'(ready[0]), 16'h0000);
    applyStimulus(L, L, L, H, 16'h0000);
    checkOutput("idle no read", 16'(bus_oe[0]), 16'h0000);
    applyStimulus(H, L, H, H, 16'h0000);

    startRead(16'h0010);
    checkOutput("pre-reset oe", 16'(bus_oe[0]), 16'h0001);
    n_reset = 1'b0;
    #1;
    checkOutput("async reset oe", 16'(bus_oe[0]), 16'h0000);
    checkOutput("async reset ready", 16'(ready[0]), 16'h0000);
    checkOutput("async reset data", bus_out[0], 16'h0000);
    checkOutput("async reset err", 16'(err[0]), 16'h0000);
    repeat (2) @(posedge clock);
    #2;
    n_reset = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      logic       me, a, oe, we;
      logic [15:0] bus;
      me = ($urandom_range(0, 19) == 0);
      a  = ($urandom_range(0, 7) == 0);
      oe = ($urandom_range(0, 2) != 0);
      we = ($urandom_range(0, 2) != 0);
      if (a) begin
        case ($urandom_range(0, 3))
          0:       bus = 16'(16'h03FE + 16'($urandom_range(0, 3)));
          1:       bus = 16'($urandom);
          default: bus = 16'($urandom_range(0, 31));
        endcase
      end else begin
        bus = 16'($urandom);
      end
      applyStimulus(me, a, oe, we, bus);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Memory-side responder for the processor's multiplexed address/data system bus. It latches an address when the address-latch strobe is asserted, then serves a single read (drives data onto the bus) or a single write (captures bus data into an internal word array) under chip-enable, output-enable and write-enable control. It is the behavioural memory the CPU fetch/execute sequencer talks to, and it replaces an ideal RAM in system simulation.

## Interface
- DATA_W, 16: bus and word width.
- DEPTH, 1024: words in the internal array; valid addresses are 0..DEPTH-1.
- READ_LAT, 1: cycles from read start to data driven (1..4).

- Clock  in  1  rising-edge clock.
- nReset  in  1  reset, asynchronous, active-low.
- nME  in  1  chip enable, active-low.
- ALE  in  1  address latch enable, active-high.
- nOE  in  1  output enable, active-low.
- nWE  in  1  write enable, active-low.
- BusIn  in  DATA_W  bus value seen at the pad (address during ALE, write data otherwise).
- BusOut  out  DATA_W  read data driven to the pad.
- BusOe  out  1  pad drive enable; BusOut is valid only while high.
- Ready  out  1  read data valid, or write committed (one-cycle pulse for writes).
- Err  out  1  sticky protocol/range error for the current transaction.

## Operation
- All controls are sampled at the rising edge of Clock. There is no combinational path from inputs to outputs.
- States:
  - IDLE: no transaction.
  - ADDR: address held.
  - RWAIT: read latency count.
  - RDRIVE: driving read data.
  - WDONE: write committed.
  - ERR: protocol error.
- IDLE -> ADDR when nME=0 and ALE=1. Latches Addr=BusIn and clears Err.
- In any state, nME=0 and ALE=1 starts a new transaction: latch a new address, clear Err, go to ADDR. This aborts any read in progress, and BusOe drops on the same edge.
- ADDR with nOE=0, nWE=1:
  - READ_LAT=1: go to RDRIVE.
  - READ_LAT>1: go to RWAIT and load counter = READ_LAT-1.
- RWAIT decrements the counter each edge and goes to RDRIVE when it reaches 1.
- RDRIVE:
  - Outputs BusOe=1, Ready=1, BusOut=mem[Addr].
  - Stays while nOE=0 and nME=0. The same address is re-read; no auto-increment.
  - nOE=1 returns to ADDR, with drive off the next edge.
- ADDR with nWE=0, nOE=1:
  - Writes mem[Addr]=BusIn on that edge, exactly once.
  - Goes to WDONE, where Ready=1 for one cycle.
  - Stays in WDONE with no further writes until nWE=1, then returns to ADDR.
- nOE=0 and nWE=0 sampled together in ADDR, RWAIT or RDRIVE:
  - Go to ERR: Err=1, BusOe=0, no write.
  - ERR exits only on a new ALE or nME=1.
- Address range check: Addr >= DEPTH sets Err=1.
  - Reads drive 0 with Ready=1.
  - Writes are dropped; Ready still pulses.
- Address width: Addr is DATA_W bits and indexes the array with its low log2(DEPTH) bits only after the range check.
- nME=1 sampled in any state forces IDLE. BusOe=0 and Ready=0 from the next edge; Err is held.
- ALE=1 while nME=1 is ignored.
- BusOe is never high in any state other than RDRIVE.

## Timing
- Reset values: BusOut=0, BusOe=0, Ready=0, Err=0, state IDLE, Addr=0.
  - Array contents are not reset.
  - Reset mid-read drops BusOe asynchronously.
  - Reset mid-write leaves the target word either old or new, never partial.
- Read latency: with ALE at edge n and nOE=0 at edge n+1, BusOe/Ready/BusOut are valid after edge n+1+READ_LAT-1. READ_LAT=1 gives valid after edge n+1.
- Write: with nWE=0 sampled at edge m, the array is updated at edge m and Ready is high for the cycle after edge m.
- Bus turnaround: BusOe deasserts on the first edge sampling nOE=1. The initiator must not drive BusIn as data in that same cycle.
- Back-to-back: ALE may be asserted in the cycle right after RDRIVE or WDONE. No dead cycle is required.

## Test plan
- Write then read, READ_LAT=1:
  - Stimulus: ALE with BusIn=0x0010, then nWE=0 with BusIn=0xBEEF; new ALE at 0x0010, then nOE=0.
  - Response: Ready pulse after the write; BusOe=1 and BusOut=0xBEEF one edge after nOE sampled low; Err=0.
- READ_LAT=3 read of 0x0005 (preloaded 0x1234): BusOe stays 0 for two cycles after nOE low, then BusOut=0x1234 with Ready=1.
- Held nWE: nWE held low 4 cycles at 0x0020 while BusIn changes 0x1111 -> 0x2222. Only 0x1111 is stored; a read-back returns 0x1111.
- Protocol error: nOE=0 and nWE=0 together after ALE at 0x0030 (old 0xAAAA).
  - Response: Err=1, BusOe=0, word unchanged at 0xAAAA.
  - A new ALE clears Err.
- Out of range, DEPTH=1024: write to 0x0400, then read 0x0400 -> BusOut=0, Err=1, Ready=1. Word 0x0000 is unaffected.
- Abort and reset:
  - nME=1 mid-read -> BusOe=0 next edge, state IDLE.
  - nReset low mid-drive -> BusOe=0 immediately, all outputs at reset values.
